// File: rtl/crc_err_mon.sv
// Error monitor for the CRC checker: counts errors, tracks a leaky-bucket error rate
// and raises a sticky fault request to the safety manager until it is acknowledged.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// OK       | bucket empty, link healthy
// DEGRADED | bucket non-empty and below threshold, errors being leaked away
// FAULT    | bucket hit threshold; fault_req held until fault_ack
module crc_err_mon #(
    parameter int CNT_WIDTH    = 8,
    parameter int BKT_WIDTH    = 4,
    parameter int FAULT_THRESH = 4,
    parameter int WINDOW       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 chk_valid,
    input  logic                 err_detected,
    input  logic                 fault_ack,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic [BKT_WIDTH-1:0] bkt_lvl,
    output logic [1:0]           state,
    output logic                 fault_req
);

    localparam int WIN_W = $clog2(WINDOW + 1);

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_DEG   = 2'b01;
    localparam logic [1:0] ST_FAULT = 2'b10;

    localparam logic [BKT_WIDTH:0]   THRESH_X = (BKT_WIDTH + 1)'(FAULT_THRESH);
    localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(WINDOW);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [BKT_WIDTH-1:0] bkt_q, bkt_d;
    logic [WIN_W-1:0]     win_q, win_d;
    logic [1:0]           state_q, state_d;
    logic                 fault_req_q, fault_req_d;

    logic                 err_sample;
    logic                 clean_sample;
    logic [BKT_WIDTH:0]   bkt_inc;
    logic [WIN_W-1:0]     win_inc;

    assign err_sample   = chk_valid & err_detected;
    assign clean_sample = chk_valid & ~err_detected;
    assign bkt_inc      = {1'b0, bkt_q} + 1'b1;
    assign win_inc      = win_q + 1'b1;

    always_comb begin
        err_cnt_d   = err_cnt_q;
        bkt_d       = bkt_q;
        win_d       = win_q;
        state_d     = state_q;

        // Errors are counted in every state, including FAULT.
        if (err_sample && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end

        case (state_q)
            ST_OK, ST_DEG: begin
                if (err_sample) begin
                    win_d = '0;
                    if (bkt_inc >= THRESH_X) begin
                        bkt_d   = THRESH_X[BKT_WIDTH-1:0];
                        state_d = ST_FAULT;
                    end else begin
                        bkt_d   = bkt_inc[BKT_WIDTH-1:0];
                        state_d = ST_DEG;
                    end
                end else if (clean_sample) begin
                    if (win_inc == WIN_LAST) begin
                        win_d = '0;
                        if (bkt_q != '0) begin
                            bkt_d = bkt_q - 1'b1;
                        end
                    end else begin
                        win_d = win_inc;
                    end
                    state_d = (bkt_d == '0) ? ST_OK : ST_DEG;
                end
            end
            ST_FAULT: begin
                // Ack only counts once fault_req has been visible for a cycle.
                if (fault_ack && fault_req_q) begin
                    bkt_d   = '0;
                    win_d   = '0;
                    state_d = ST_OK;
                end
            end
            default: state_d = ST_OK;
        endcase

        fault_req_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q   <= '0;
            bkt_q       <= '0;
            win_q       <= '0;
            state_q     <= ST_OK;
            fault_req_q <= 1'b0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            bkt_q       <= bkt_d;
            win_q       <= win_d;
            state_q     <= state_d;
            fault_req_q <= fault_req_d;
        end
    end

    assign err_cnt   = err_cnt_q;
    assign bkt_lvl   = bkt_q;
    assign state     = state_q;
    assign fault_req = fault_req_q;

    a_req_matches_state: assert property (@(posedge clk) disable iff (rst)
        fault_req_q == (state_q == ST_FAULT));
    a_bkt_bounded: assert property (@(posedge clk) disable iff (rst)
        {1'b0, bkt_q} <= THRESH_X);
    a_state_legal: assert property (@(posedge clk) disable iff (rst)
        state_q != 2'b11);

endmodule

// File: tb/tb_crc_err_mon.sv
// Scoreboard bench for crc_err_mon: directed scenarios then weighted random traffic,
// each cycle's expected outputs come from a rule-level model and are checked by a monitor.
module tb_crc_err_mon;

    localparam int TH  = 4;
    localparam int WIN = 16;
    localparam int CMX = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       chk_valid = 1'b0;
    logic       err_detected = 1'b0;
    logic       fault_ack = 1'b0;
    logic [7:0] err_cnt;
    logic [3:0] bkt_lvl;
    logic [1:0] state;
    logic       fault_req;

    crc_err_mon #(
        .CNT_WIDTH(8), .BKT_WIDTH(4), .FAULT_THRESH(TH), .WINDOW(WIN)
    ) dut (
        .clk(clk), .rst(rst), .chk_valid(chk_valid), .err_detected(err_detected),
        .fault_ack(fault_ack), .err_cnt(err_cnt), .bkt_lvl(bkt_lvl),
        .state(state), .fault_req(fault_req)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] cnt;
        logic [3:0] bkt;
        logic [1:0] st;
        logic       req;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: health levels 0=OK, 1=DEGRADED, 2=FAULT.
    int m_cnt = 0, m_bkt = 0, m_clean_run = 0, m_health = 0;

    function automatic void model_step(input bit r, input bit v, input bit e, input bit a);
        if (r) begin
            m_cnt = 0; m_bkt = 0; m_clean_run = 0; m_health = 0;
            return;
        end
        if (v && e) m_cnt = (m_cnt + 1 > CMX) ? CMX : m_cnt + 1;
        if (m_health == 2) begin
            if (a) begin
                m_health = 0; m_bkt = 0; m_clean_run = 0;
            end
        end else if (v && e) begin
            m_clean_run = 0;
            m_bkt = m_bkt + 1;
            if (m_bkt >= TH) begin
                m_bkt = TH;
                m_health = 2;
            end else begin
                m_health = 1;
            end
        end else if (v) begin
            m_clean_run++;
            if (m_clean_run == WIN) begin
                m_clean_run = 0;
                if (m_bkt > 0) m_bkt--;
            end
            m_health = (m_bkt == 0) ? 0 : 1;
        end
    endfunction

    task automatic step(input bit r, input bit v, input bit e, input bit a);
        exp_t x;
        @(negedge clk);
        rst = r; chk_valid = v; err_detected = e; fault_ack = a;
        @(posedge clk);
        model_step(r, v, e, a);
        x.cnt = 8'(m_cnt);
        x.bkt = 4'(m_bkt);
        x.st  = 2'(m_health);
        x.req = (m_health == 2);
        exp_q.push_back(x);
    endtask

    task automatic repeat_step(input int n, input bit v, input bit e, input bit a);
        for (int i = 0; i < n; i++) step(1'b0, v, e, a);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                n_vec++;
                if (err_cnt !== x.cnt) begin
                    n_err++;
                    $display("FAIL err_cnt @%0t: got %0d expected %0d", $time, err_cnt, x.cnt);
                end
                if (bkt_lvl !== x.bkt) begin
                    n_err++;
                    $display("FAIL bkt_lvl @%0t: got %0d expected %0d", $time, bkt_lvl, x.bkt);
                end
                if (state !== x.st) begin
                    n_err++;
                    $display("FAIL state @%0t: got %b expected %b", $time, state, x.st);
                end
                if (fault_req !== x.req) begin
                    n_err++;
                    $display("FAIL fault_req @%0t: got %b expected %b", $time, fault_req, x.req);
                end
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int pct_err;
        bit r, v, e, a;

        step(1, 0, 0, 0);
        step(1, 1, 1, 1);

        repeat_step(100, 1, 0, 0);

        step(0, 1, 1, 0);
        repeat_step(16, 1, 0, 0);
        step(0, 0, 0, 0);

        step(0, 1, 1, 0);
        repeat_step(10, 1, 0, 0);
        step(0, 1, 1, 0);
        repeat_step(15, 1, 0, 0);
        repeat_step(5, 0, 0, 0);
        step(1, 0, 0, 0);

        repeat_step(4, 1, 1, 0);
        repeat_step(3, 1, 1, 0);
        repeat_step(3, 1, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        repeat_step(4, 1, 1, 0);
        step(0, 1, 1, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Ack held high while re-entering FAULT.
        repeat_step(6, 1, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        for (int i = 0; i < 300; i++) step(0, 1, 1, (i % 10) == 9);
        repeat_step(4, 1, 1, 0);
        step(1, 1, 1, 0);
        step(0, 0, 0, 0);

        for (int blk = 0; blk < 6; blk++) begin
            case (blk % 3)
                0: pct_err = 5;
                1: pct_err = 25;
                default: pct_err = 60;
            endcase
            for (int i = 0; i < 500; i++) begin
                r = ($urandom_range(0, 299) == 0);
                v = ($urandom_range(0, 99) < 75);
                e = ($urandom_range(0, 99) < pct_err);
                a = ($urandom_range(0, 99) < 8);
                step(r, v, e, a);
            end
        end

        step(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/crc_err_mon.md
Name: crc_err_mon

Overview:
- Downstream consumer of the CRC checker's registered error flag.
- Qualifies each check result with a valid strobe, keeps a saturating total error count and a leaky-bucket error-rate estimate, and classifies link health as OK / DEGRADED / FAULT.
- On FAULT, raises a sticky request/acknowledge handshake to the safety manager.
- Sits between the checker's err_detected output and the system fault-collection logic.

Parameters:
- CNT_WIDTH, 8, width of total error counter err_cnt (saturating).
- BKT_WIDTH, 4, width of leaky-bucket counter; must hold FAULT_THRESH.
- FAULT_THRESH, 4, bucket level that enters FAULT; legal range 1..2^BKT_WIDTH-1.
- WINDOW, 16, consecutive error-free valid samples needed to leak one bucket unit; >=1.

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- chk_valid  input  1  err_detected carries a valid check result this cycle.
- err_detected  input  1  CRC mismatch flag from checker; ignored when chk_valid=0.
- fault_ack  input  1  safety-manager acknowledge of fault_req.
- err_cnt  output  CNT_WIDTH  total errors since reset, saturating.
- bkt_lvl  output  BKT_WIDTH  current leaky-bucket level.
- state  output  2  00=OK, 01=DEGRADED, 10=FAULT (11 unused, never driven).
- fault_req  output  1  fault request, high exactly while state=FAULT.

Behaviour:
- Clocking/reset:
  - Single clock domain.
  - rst high at a rising edge: err_cnt=0, bkt_lvl=0, internal window counter=0, state=OK, fault_req=0. Reset has priority over all other inputs.
  - Reset mid-FAULT clears everything without needing fault_ack.
- Latency: a sample (chk_valid=1) at edge N is reflected in err_cnt, bkt_lvl, state and fault_req after edge N. All outputs are registered; there are no combinational paths from inputs to outputs.
- Error sample (chk_valid=1, err_detected=1):
  - err_cnt += 1, saturating at 2^CNT_WIDTH-1. Counted in every state.
  - Window counter cleared.
  - In OK/DEGRADED: bkt_lvl += 1. If the new level is >= FAULT_THRESH, bkt_lvl = FAULT_THRESH and state goes to FAULT; otherwise state goes to DEGRADED.
- Clean sample (chk_valid=1, err_detected=0), in OK/DEGRADED only:
  - Window counter += 1.
  - When it reaches WINDOW: the window counter is cleared and, if bkt_lvl>0, bkt_lvl -= 1.
  - If bkt_lvl becomes 0, state goes to OK; otherwise state stays DEGRADED.
- chk_valid=0: no counter or state change; the window counter holds its value (no time-based leak).
- FAULT state:
  - bkt_lvl and window counter frozen; fault_req=1.
  - fault_ack=1 at an edge: next cycle state=OK, bkt_lvl=0, window counter=0, fault_req=0.
- Simultaneous fault_ack and error sample in FAULT: ack wins for state/bucket; the error still increments err_cnt. The bucket is not re-incremented, so the next state is OK.
- fault_ack while not in FAULT: ignored.
- fault_ack held high across re-entry to FAULT: a new FAULT requires at least one cycle with fault_req=1 before the ack is honoured. Ack is sampled only when fault_req=1 in the same cycle.
- State transitions:
  - OK -> DEGRADED on error.
  - OK -> FAULT directly on error if FAULT_THRESH=1.
  - DEGRADED -> OK on leak to 0.
  - DEGRADED -> FAULT on error reaching threshold.
  - FAULT -> OK on ack.
  - No other transitions.
- Simulation assertions:
  - fault_req == (state==FAULT).
  - bkt_lvl <= FAULT_THRESH.
  - state != 2'b11.

Test Plan (defaults: FAULT_THRESH=4, WINDOW=16, CNT_WIDTH=8):
- Reset, then 100 clean valid samples -> err_cnt=0, bkt_lvl=0, state=OK, fault_req=0 throughout.
- One error sample, then 15 clean samples -> bkt_lvl=1, DEGRADED. 16th clean sample -> bkt_lvl=0, state=OK one cycle later.
- Error, 10 clean, error, 15 clean -> bkt_lvl=2, no leak, because the window counter was cleared by the second error.
- 4 back-to-back errors -> state=FAULT and fault_req=1 on the edge after the 4th error, bkt_lvl=4. Further errors increment err_cnt only. fault_ack pulse -> state=OK, bkt_lvl=0 next cycle.
- In FAULT, fault_ack and an error in the same cycle -> state=OK, bkt_lvl=0, err_cnt +1. fault_ack pulse while OK -> no change.
- 300 errors with periodic acks -> err_cnt saturates at 255. rst asserted during FAULT -> all outputs 0 / OK on the next edge.
